// File: rtl/decoder_rr_scheduler.sv
// Round-robin scheduler with hold limit and forced idle gap.
// Grant lines are decoded from the registered owner index.

module bin2onehot #(
    parameter int k = 3
) (
    input  logic              enable,
    input  logic [k-1:0]      in,
    output logic [(1<<k)-1:0] out
);

    // One-hot decode of the binary index, gated by enable
    always_comb begin
        out = '0;
        if (enable) out[in] = 1'b1;
    end

endmodule

module decoder_rr_scheduler #(
    parameter int k        = 3,
    parameter int HOLD_MAX = 15
) (
`ifdef USE_POWER_PINS
    inout  wire               vccd1,
    inout  wire               vssd1,
`endif
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [(1<<k)-1:0] req,
    output logic [(1<<k)-1:0] gnt,
    output logic [k-1:0]      gnt_idx,
    output logic              gnt_valid,
    output logic              timeout
);

    localparam int N  = 1 << k;
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HW-1:0] HMAX = HW'(HOLD_MAX);
    localparam logic [HW-1:0] HONE = HW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        r_state, w_state;
    logic [k-1:0]  r_ptr,   w_ptr;
    logic [k-1:0]  r_idx,   w_idx;
    logic [HW-1:0] r_hold,  w_hold;
    logic          r_to,    w_to;

    logic          w_found;
    logic [k-1:0]  w_win;
    logic [k-1:0]  w_cand;
    logic [k-1:0]  w_next_ptr;

    // Winner search: first active request at or after the pointer, cyclic
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int j = 0; j < N; j++) begin
            w_cand = r_ptr + j[k-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_next_ptr = r_idx + 1'b1;

    // Next-state and next-register logic
    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_idx   = r_idx;
        w_hold  = r_hold;
        w_to    = 1'b0;
        unique case (r_state)
            IDLE, GAP: begin
                if (w_found) begin
                    w_idx   = w_win;
                    w_hold  = HONE;
                    w_state = GRANT;
                end else begin
                    w_state = IDLE;
                end
            end
            GRANT: begin
                if (!req[r_idx]) begin
                    w_state = GAP;
                    w_ptr   = w_next_ptr;
                end else if (HOLD_MAX != 0 && r_hold == HMAX) begin
                    w_state = GAP;
                    w_ptr   = w_next_ptr;
                    w_to    = 1'b1;
                end else begin
                    w_hold = r_hold + HONE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_hold  <= '0;
            r_to    <= 1'b0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_idx   <= w_idx;
            r_hold  <= w_hold;
            r_to    <= w_to;
        end
    end

    assign gnt_valid = (r_state == GRANT);
    assign gnt_idx   = r_idx;
    assign timeout   = r_to;

    bin2onehot #(
        .k(k)
    ) u_dec (
        .enable (gnt_valid),
        .in     (r_idx),
        .out    (gnt)
    );

endmodule

// File: tb/tb_decoder_rr_scheduler.sv
// Randomised and directed check of decoder_rr_scheduler
// against a behavioural round-robin model.

module tb_decoder_rr_scheduler;

    localparam int K  = 3;
    localparam int N  = 1 << K;
    localparam int HM = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [K-1:0] gnt_idx;
    logic         gnt_valid;
    logic         timeout;

    int n_vec;
    int n_bad;

    decoder_rr_scheduler #(
        .k(K),
        .HOLD_MAX(HM)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: owner < 0 means nobody holds the resource
    int m_owner;
    int m_last;
    int m_ptr;
    int m_held;
    bit m_gap;
    bit m_to;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_gap   = 0;
        m_to    = 0;
    endtask

    task automatic m_step(input bit r, input logic [N-1:0] rq);
        if (r) begin
            m_reset();
            return;
        end
        m_to = 0;
        if (m_owner < 0) begin
            m_gap = 0;
            for (int j = 0; j < N; j++) begin
                if (m_owner < 0 && rq[(m_ptr + j) % N]) begin
                    m_owner = (m_ptr + j) % N;
                end
            end
            if (m_owner >= 0) begin
                m_last = m_owner;
                m_held = 1;
            end
        end else if (!rq[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_gap   = 1;
        end else if (m_held == HM) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_gap   = 1;
            m_to    = 1;
        end else begin
            m_held++;
        end
    endtask

    task automatic cyc(input bit r, input logic [N-1:0] rq);
        int eg;
        rst = r;
        req = rq;
        @(posedge clk);
        m_step(r, rq);
        #1;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk("gnt", int'(gnt), eg);
        chk("gnt_idx", int'(gnt_idx), m_last);
        chk("gnt_valid", int'(gnt_valid), int'(m_owner >= 0));
        chk("timeout", int'(timeout), int'(m_to));
        chk("onehot", int'($countones(gnt) <= 1), 1);
    endtask

    logic [N-1:0] rq;
    int seq[$];
    int gaps;
    int hold_exp[10];
    int to_exp[10];

    initial begin
        n_vec = 0;
        n_bad = 0;
        m_reset();
        rst = 1'b1;
        req = '0;

        // reset with everyone requesting
        cyc(1, 8'hFF);
        cyc(1, 8'hFF);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_idx", int'(gnt_idx), 0);
        cyc(0, 8'hFF);
        chk("first_gnt", int'(gnt), 8'h01);

        // rotation: owners release after two granted cycles
        seq.delete();
        seq.push_back(0);
        gaps = 0;
        for (int c = 0; c < 40 && seq.size() < 9; c++) begin
            rq = 8'hFF;
            if (m_owner >= 0 && m_held == 2) rq[m_owner] = 1'b0;
            cyc(0, rq);
            if (!gnt_valid) gaps++;
            if (gnt_valid && m_held == 1) begin
                chk("rot_gap", gaps, 1);
                gaps = 0;
                seq.push_back(int'(gnt_idx));
            end
        end
        chk("rot_len", seq.size(), 9);
        foreach (seq[i]) chk("rot_order", seq[i], i % N);

        // pointer wrap after owner 5 releases
        cyc(1, 8'h00);
        cyc(0, 8'h20);
        chk("wrap_own5", int'(gnt), 8'h20);
        cyc(0, 8'h05);
        chk("wrap_gap", int'(gnt_valid), 0);
        cyc(0, 8'h05);
        chk("wrap_to0", int'(gnt), 8'h01);
        cyc(0, 8'h04);
        cyc(0, 8'h04);
        chk("wrap_to2", int'(gnt), 8'h04);

        // hold limit with two contenders
        hold_exp = '{1, 1, 1, 1, 0, 8, 8, 8, 8, 0};
        to_exp   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        cyc(1, 8'h00);
        for (int c = 0; c < 10; c++) begin
            cyc(0, 8'h09);
            chk("hold_gnt", int'(gnt), hold_exp[c]);
            chk("hold_to", int'(timeout), to_exp[c]);
        end
        cyc(0, 8'h09);
        chk("hold_back0", int'(gnt), 8'h01);

        // release exactly on the limit cycle
        cyc(1, 8'h00);
        for (int c = 0; c < 4; c++) cyc(0, 8'h01);
        cyc(0, 8'h00);
        chk("lim_rel_valid", int'(gnt_valid), 0);
        chk("lim_rel_to", int'(timeout), 0);

        // reset while index 5 owns the resource
        cyc(1, 8'h00);
        cyc(0, 8'h20);
        chk("mid_own5", int'(gnt), 8'h20);
        cyc(1, 8'hFF);
        chk("mid_gnt", int'(gnt), 0);
        chk("mid_to", int'(timeout), 0);
        cyc(0, 8'hFF);
        chk("mid_restart", int'(gnt), 8'h01);

        // random traffic
        rq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            end
            cyc(($urandom_range(0, 99) == 0), rq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
